// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receive front end: frame deserializer, 3-byte packet assembler
// and button/delta decode, clocked directly by the (inverted) bus clock.
// Optional position integrator with clamping, built when PS2RX_ACCUM_EN is
// defined; otherwise x and y are tied to 0.
module ps2_mouse_packet_rx #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic              PS2_CLK,
  input  logic              reset,
  input  logic              PS2_DAT,
  output logic              pkt_valid,
  output logic              btn_left,
  output logic              btn_right,
  output logic              btn_middle,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic              frame_err
);

`ifdef PS2RX_ACCUM_EN
  // Header keeps {y_ovf, x_ovf, y_sign, x_sign, buttons}
  localparam int unsigned HDR_W = 7;
`else
  // Header keeps {y_sign, x_sign, buttons}
  localparam int unsigned HDR_W = 5;
`endif

  // Position registers are 11 bits wide, so screen dimensions must fit
  if (WIDTH < 2 || WIDTH > 2048 || HEIGHT < 2 || HEIGHT > 2048) begin : g_dim_check
    $error("ps2_mouse_packet_rx: WIDTH and HEIGHT must lie in 2..2048");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        sr_q, sr_d;
  logic              par_q, par_d;
  logic [1:0]        pidx_q, pidx_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [7:0]        b1_q, b1_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [2:0]        btn_q, btn_d;
  logic signed [8:0] dx_q, dx_d;
  logic signed [8:0] dy_q, dy_d;
  logic signed [8:0] dx_new, dy_new;
`ifdef PS2RX_ACCUM_EN
  localparam logic signed [11:0] X_MAX = 12'(WIDTH - 1);
  localparam logic signed [11:0] Y_MAX = 12'(HEIGHT - 1);
  logic [10:0]        x_q, x_d, y_q, y_d;
  logic signed [11:0] x_sum, y_sum;
`endif

  // Deltas of the packet completing on this edge (byte 2 is still in sr_q)
  assign dx_new = {hdr_q[3], b1_q};
  assign dy_new = {hdr_q[4], sr_q};

  // State and datapath registers; reset discards any partial frame or packet
  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      pidx_q   <= '0;
      hdr_q    <= '0;
      b1_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      btn_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
`ifdef PS2RX_ACCUM_EN
      x_q      <= 11'(WIDTH / 2);
      y_q      <= 11'(HEIGHT / 2);
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      pidx_q   <= pidx_d;
      hdr_q    <= hdr_d;
      b1_q     <= b1_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      btn_q    <= btn_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
`ifdef PS2RX_ACCUM_EN
      x_q      <= x_d;
      y_q      <= y_d;
`endif
    end
  end

  // Frame FSM, packet assembly, decode and position integration
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    pidx_d   = pidx_q;
    hdr_d    = hdr_q;
    b1_d     = b1_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    btn_d    = btn_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
`ifdef PS2RX_ACCUM_EN
    x_d      = x_q;
    y_d      = y_q;
    x_sum    = $signed({1'b0, x_q}) + 12'(dx_new);
    y_sum    = $signed({1'b0, y_q}) - 12'(dy_new);
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!PS2_DAT) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: begin
        sr_d = {PS2_DAT, sr_q[7:1]};
        if (bitcnt_q == 3'd7) state_d = S_PARITY;
        else                  bitcnt_d = bitcnt_q + 3'd1;
      end
      S_PARITY: begin
        par_d   = PS2_DAT;
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        if (PS2_DAT && ((^sr_q) ^ par_q)) begin
          err_d = 1'b0;
          unique case (pidx_q)
            2'd0: begin
              // Byte 0 must carry the always-one sync bit, else resync
              if (sr_q[3]) begin
                hdr_d  = HDR_W'({sr_q[7:4], sr_q[2:0]});
                pidx_d = 2'd1;
              end
            end
            2'd1: begin
              b1_d   = sr_q;
              pidx_d = 2'd2;
            end
            default: begin
              pidx_d  = 2'd0;
              valid_d = 1'b1;
              btn_d   = hdr_q[2:0];
              dx_d    = dx_new;
              dy_d    = dy_new;
`ifdef PS2RX_ACCUM_EN
              // Overflowed axes keep their position; screen Y grows downward
              if (!hdr_q[5]) begin
                if (x_sum < 12'sd0)      x_d = '0;
                else if (x_sum > X_MAX)  x_d = 11'(X_MAX);
                else                     x_d = 11'(x_sum);
              end
              if (!hdr_q[6]) begin
                if (y_sum < 12'sd0)      y_d = '0;
                else if (y_sum > Y_MAX)  y_d = 11'(Y_MAX);
                else                     y_d = 11'(y_sum);
              end
`endif
            end
          endcase
        end else begin
          err_d  = 1'b1;
          pidx_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pkt_valid  = valid_q;
  assign frame_err  = err_q;
  assign btn_left   = btn_q[0];
  assign btn_right  = btn_q[1];
  assign btn_middle = btn_q[2];
  assign dx         = dx_q;
  assign dy         = dy_q;
`ifdef PS2RX_ACCUM_EN
  assign x          = x_q;
  assign y          = y_q;
`else
  assign x          = '0;
  assign y          = '0;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: byte-level reference model, per-cycle
// compare on the falling edge, directed packets plus randomized traffic.
module tb_ps2_mouse_packet_rx;
  localparam int W = 640;
  localparam int H = 480;
`ifdef PS2RX_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic              PS2_CLK = 1'b0;
  logic              reset   = 1'b0;
  logic              PS2_DAT = 1'b1;
  logic              pkt_valid, btn_left, btn_right, btn_middle, frame_err;
  logic signed [8:0] dx, dy;
  logic [10:0]       x, y;

  ps2_mouse_packet_rx #(.WIDTH(W), .HEIGHT(H)) dut (
    .PS2_CLK(PS2_CLK), .reset(reset), .PS2_DAT(PS2_DAT),
    .pkt_valid(pkt_valid), .btn_left(btn_left), .btn_right(btn_right),
    .btn_middle(btn_middle), .dx(dx), .dy(dy), .x(x), .y(y),
    .frame_err(frame_err)
  );

  always #5 PS2_CLK = ~PS2_CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int pulses = 0;

  // Reference model state, expressed in bytes and integers
  bit       m_valid, m_err;
  bit [2:0] m_btn;
  int       m_dx, m_dy, m_x, m_y, m_pidx;
  bit [7:0] m_pkt [3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int acc(input int v);
    return ACC ? v : 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_btn = 0; m_dx = 0; m_dy = 0; m_pidx = 0;
    m_x = acc(W / 2);
    m_y = acc(H / 2);
  endtask

  task automatic model_byte(input bit [7:0] b, input bit good);
    if (!good) begin
      m_err = 1; m_pidx = 0;
      return;
    end
    m_err = 0;
    if (m_pidx == 0) begin
      if (b[3]) begin m_pkt[0] = b; m_pidx = 1; end
    end else if (m_pidx == 1) begin
      m_pkt[1] = b; m_pidx = 2;
    end else begin
      m_pkt[2] = b; m_pidx = 0; m_valid = 1;
      m_btn = m_pkt[0][2:0];
      m_dx  = m_pkt[0][4] ? int'(m_pkt[1]) - 256 : int'(m_pkt[1]);
      m_dy  = m_pkt[0][5] ? int'(m_pkt[2]) - 256 : int'(m_pkt[2]);
      if (ACC && !m_pkt[0][6]) m_x = clamp(m_x + m_dx, 0, W - 1);
      if (ACC && !m_pkt[0][7]) m_y = clamp(m_y - m_dy, 0, H - 1);
    end
  endtask

  // One bus bit: drive on the falling edge, let the DUT sample on the rising edge
  task automatic edge_bit(input bit v);
    @(negedge PS2_CLK);
    PS2_DAT = v;
    @(posedge PS2_CLK);
    #1;
    m_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) edge_bit(1'b1);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    bit p;
    p = (~^b) ^ bad_par;
    edge_bit(1'b0);
    for (int i = 0; i < 8; i++) edge_bit(b[i]);
    edge_bit(p);
    edge_bit(!bad_stop);
    model_byte(b, !(bad_par || bad_stop));
  endtask

  task automatic partial_frame(input int nbits);
    edge_bit(1'b0);
    for (int i = 0; i < nbits; i++) edge_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(negedge PS2_CLK);
    reset = 1'b1; PS2_DAT = 1'b1;
    repeat (2) begin
      @(posedge PS2_CLK);
      #1;
      model_reset();
    end
    reset = 1'b0;
  endtask

  // Per-cycle compare against the model, away from the sampling edge
  always @(negedge PS2_CLK) begin
    if (chk_en) begin
      check("cyc_pkt_valid", int'(pkt_valid), int'(m_valid));
      check("cyc_frame_err", int'(frame_err), int'(m_err));
      check("cyc_btn_left", int'(btn_left), int'(m_btn[0]));
      check("cyc_btn_right", int'(btn_right), int'(m_btn[1]));
      check("cyc_btn_middle", int'(btn_middle), int'(m_btn[2]));
      check("cyc_dx", int'(dx), m_dx);
      check("cyc_dy", int'(dy), m_dy);
      check("cyc_x", int'(x), m_x);
      check("cyc_y", int'(y), m_y);
      if (pkt_valid === 1'b1) pulses++;
    end
  end

  initial begin
    bit [7:0] b;
    int r;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_pkt_valid", int'(pkt_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_buttons", int'({btn_middle, btn_right, btn_left}), 0);
    check("rst_dx", int'(dx), 0);
    check("rst_dy", int'(dy), 0);
    check("rst_x", int'(x), acc(320));
    check("rst_y", int'(y), acc(240));

    // Valid packet
    idle(2);
    send_byte(8'h09); send_byte(8'h05); send_byte(8'h03);
    check("pkt_valid_set", int'(pkt_valid), 1);
    check("pkt_btn_left", int'(btn_left), 1);
    check("pkt_dx", int'(dx), 5);
    check("pkt_dy", int'(dy), 3);
    check("pkt_x", int'(x), acc(325));
    check("pkt_y", int'(y), acc(237));
    edge_bit(1'b1);
    check("pkt_valid_clear", int'(pkt_valid), 0);

    // Parity error on byte 1, then a clean packet
    idle(1);
    send_byte(8'h08); send_byte(8'h05, 1'b1, 1'b0);
    check("par_frame_err", int'(frame_err), 1);
    check("par_no_valid", int'(pkt_valid), 0);
    send_byte(8'h0A); send_byte(8'h00); send_byte(8'h00);
    check("par_btn_right", int'(btn_right), 1);
    check("par_pkt_valid", int'(pkt_valid), 1);
    check("par_err_clear", int'(frame_err), 0);

    // Stop-bit error also drops the byte
    send_byte(8'h09, 1'b0, 1'b1);
    check("stop_frame_err", int'(frame_err), 1);

    // Sync loss: stray byte discarded
    do_reset();
    send_byte(8'h00); send_byte(8'h08); send_byte(8'hFF); send_byte(8'h01);
    check("sync_dx", int'(dx), 255);
    check("sync_dy", int'(dy), 1);
    check("sync_x", int'(x), acc(575));
    check("sync_y", int'(y), acc(239));

    // Clamp and overflow: walk X to 100 first (dx = -220)
    do_reset();
    send_byte(8'h18); send_byte(8'h24); send_byte(8'h00);
    check("clamp_pre_x", int'(x), acc(100));
    send_byte(8'h98); send_byte(8'h00); send_byte(8'h50);
    check("clamp_dx", int'(dx), -256);
    check("clamp_dy", int'(dy), 80);
    check("clamp_x", int'(x), acc(0));
    check("clamp_y", int'(y), acc(240));

    // Mid-frame reset after 4 data bits
    do_reset();
    pulses = 0;
    partial_frame(4);
    do_reset();
    send_byte(8'h0C); send_byte(8'h01); send_byte(8'h01);
    idle(2);
    check("mid_btn_middle", int'(btn_middle), 1);
    check("mid_dx", int'(dx), 1);
    check("mid_dy", int'(dy), 1);
    check("mid_pulses", pulses, 1);

    // Randomized traffic with injected errors and occasional mid-frame resets
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 3));
      b = 8'($urandom);
      if (m_pidx == 0 && $urandom_range(0, 9) < 8) b[3] = 1'b1;
      if (m_pidx == 0 && $urandom_range(0, 3) == 0) b[7:6] = 2'b00;
      r = $urandom_range(0, 39);
      if (r == 0)      send_byte(b, 1'b1, 1'b0);
      else if (r == 1) send_byte(b, 1'b0, 1'b1);
      else if (r == 2) begin
        partial_frame($urandom_range(0, 8));
        do_reset();
      end
      else             send_byte(b);
    end
    idle(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_packet_rx.md
# ps2_mouse_packet_rx

PS/2 mouse receive front end clocked directly by the bus clock. Deserializes 11-bit device-to-host frames from `PS2_DAT`, assembles standard 3-byte mouse packets and decodes buttons and signed X/Y deltas. Optionally integrates the deltas into a clamped screen position. Its outputs feed the binning and motion-direction stage that produces `MS_DIR` and the enable/clear/middle controls.

## Interface
- `WIDTH`, default 640: screen width in pixels; X is clamped to 0..WIDTH-1.
- `HEIGHT`, default 480: screen height in pixels; Y is clamped to 0..HEIGHT-1.

Ports:
- `PS2_CLK`, in, 1: clock. All state updates on its rising edge. The integrator drives this port with the inverted bus clock, so a rising edge here is a bus falling edge (the data-valid edge).
- `reset`, in, 1: synchronous, active-high.
- `PS2_DAT`, in, 1: PS/2 data line.
- `pkt_valid`, out, 1: a complete, valid packet was decoded.
- `btn_left`, `btn_right`, `btn_middle`, out, 1 each: button state from packet byte 0, bits 0, 1 and 2 respectively.
- `dx`, out, 9, signed: {byte0[4], byte1}.
- `dy`, out, 9, signed: {byte0[5], byte2}. Positive means up.
- `x`, out, 11: accumulated X position.
- `y`, out, 11: accumulated Y position.
- `frame_err`, out, 1: the last frame was dropped because of a parity or stop-bit error.

## Operation
Frame FSM, one bit per edge:
- IDLE:
  - Sample 0 (start bit): go to DATA with `bitcnt`=0.
  - Sample 1: stay in IDLE.
- DATA: shift the sample into `sr` LSB-first. When `bitcnt`==7, go to PARITY; otherwise increment `bitcnt`.
- PARITY: store the sampled bit, then go to STOP.
- STOP: always return to IDLE afterwards.
  - The byte is good only if the sample is 1 and XOR(`sr`, parity)==1 (odd parity).
  - Good byte: pass it to the packet assembler on this edge.
  - Bad byte: set `frame_err`=1, discard the byte and reset `pidx` to 0.
- `frame_err` clears on the next good-byte edge.

Packet assembler (`pidx` 0..2):
- `pidx`=0: accept the byte only if bit3==1 (sync bit), then set `pidx`=1. Otherwise discard it and keep `pidx`=0 (resync).
- `pidx`=1 and `pidx`=2: store the byte unconditionally and advance `pidx`.
- On the good-byte edge with `pidx`=2, all of the following update together:
  - `pkt_valid`=1.
  - Buttons, `dx` and `dy` update.
  - `x`/`y` update if the accumulator is compiled in.
  - `pidx` returns to 0.

Accumulator arithmetic:
- Use 12-bit signed intermediates: x_next = x + dx and y_next = y − dy (screen Y grows downward).
- Clamp x_next to [0, WIDTH-1] and y_next to [0, HEIGHT-1].
- If byte0[6] (X overflow) is set, X is left unchanged. If byte0[7] (Y overflow) is set, Y is left unchanged.
- `dx` and `dy` are output raw regardless of the overflow bits.

Reset values:
- FSM state IDLE, `bitcnt`=0, `pidx`=0.
- `pkt_valid`=0, `frame_err`=0.
- All buttons 0, `dx`=0, `dy`=0.
- `x`=WIDTH/2 (320), `y`=HEIGHT/2 (240).

## Timing
- Latency: outputs are registered on the edge that samples the stop bit of byte 2. They are visible after that edge.
- `pkt_valid` pulse: high for exactly one `PS2_CLK` period. It clears on the next rising edge, which is normally the next frame's start bit.
  - The bus clock idles between packets, so the pulse may last arbitrarily long in wall time.
  - Consumers in other clock domains must synchronize and edge-detect it.
- Held outputs: buttons, `dx`, `dy`, `x` and `y` hold between packets.
- Reset wins over every other event on the same edge. Reset mid-frame or mid-packet discards all partial data.
- No timeout is possible, because the block has no clock while the bus is idle. Resync relies only on the stop, parity and sync-bit checks.

## Configuration
- Macro `PS2RX_ACCUM_EN`.
- Defined: the position accumulator and clamps are built as described above.
- Undefined: the accumulator logic is omitted, and `x` and `y` are tied to constant 0. All other behaviour is unchanged.

## Test plan
- **Reset:** assert `reset` for 2 edges. Require `pkt_valid`=0, `frame_err`=0, buttons=0, `dx`=0, `dy`=0, `x`=320, `y`=240.
- **Valid packet:** send bytes 0x09, 0x05, 0x03. Require `pkt_valid` for 1 cycle, `btn_left`=1, `dx`=+5, `dy`=+3, `x`=325, `y`=237.
- **Parity error:** send byte 1 with bad parity. Require `frame_err`=1, no `pkt_valid`, `pidx` reset. Then send 0x0A, 0x00, 0x00 and require `btn_right`=1, `pkt_valid`=1, `frame_err`=0.
- **Sync loss:** send stray byte 0x00, then 0x08, 0xFF, 0x01. Require the stray byte is discarded, `dx`=+255, `dy`=+1, `x`=575, `y`=239.
- **Clamp and overflow:** from `x`=100, send 0x98, 0x00, 0x50. Require `dx`=−256 and `x`=0, and `y` unchanged because the Y overflow bit is set.
- **Mid-frame reset:** assert `reset` after 4 data bits, then send 0x0C, 0x01, 0x01. Require `btn_middle`=1, `dx`=+1, `dy`=+1 and exactly one `pkt_valid`.
